idex_operand_buffer: RTL

//   Decode-to-execute operand buffer directly downstream of the 32x64 register file.

---
 rtl/idex_operand_buffer_if.sv | 39 +++
 rtl/idex_operand_buffer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/idex_operand_buffer_if.sv
// Handshake, operand and write-back signals between decode, the operand buffer and execute.
interface idex_operand_buffer_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CTRL_W = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_ra1;
    logic [ADDR_W-1:0] in_ra2;
    logic [DATA_W-1:0] in_rd1;
    logic [DATA_W-1:0] in_rd2;
    logic [ADDR_W-1:0] in_dst;
    logic [CTRL_W-1:0] in_ctrl;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_wa;
    logic [DATA_W-1:0] wb_wd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rd1;
    logic [DATA_W-1:0] out_rd2;
    logic [ADDR_W-1:0] out_dst;
    logic [CTRL_W-1:0] out_ctrl;

    // Decode / execute / write-back side
    modport master (
        output flush, in_valid, in_ra1, in_ra2, in_rd1, in_rd2, in_dst, in_ctrl,
        output wb_we, wb_wa, wb_wd, out_ready,
        input  in_ready, out_valid, out_rd1, out_rd2, out_dst, out_ctrl
    );

    // Operand buffer side
    modport slave (
        input  flush, in_valid, in_ra1, in_ra2, in_rd1, in_rd2, in_dst, in_ctrl,
        input  wb_we, wb_wa, wb_wd, out_ready,
        output in_ready, out_valid, out_rd1, out_rd2, out_dst, out_ctrl
    );
endinterface

// File: rtl/idex_operand_buffer.sv
// Decode-to-execute operand buffer: 2-entry skid (main + skid) with write-back bypass
// on capture and while operands are held.
module idex_operand_buffer #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CTRL_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    idex_operand_buffer_if.slave  bus
);
    // Highest register (XZR) reads as zero in the regfile and is never forwarded
    localparam logic [ADDR_W-1:0] XZR = '1;

    typedef struct packed {
        logic [ADDR_W-1:0] ra1;
        logic [ADDR_W-1:0] ra2;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [ADDR_W-1:0] dst;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t m_q, m_d;
    entry_t s_q, s_d;
    logic   out_valid_q, out_valid_d;
    logic   in_ready_q, in_ready_d;

    entry_t in_c;
    entry_t m_hold_c;
    entry_t s_hold_c;
    logic   accept_c;
    logic   pop_c;

    // Replace an operand with write-back data when it targets the same real register
    function automatic logic [DATA_W-1:0] fwd(
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd,
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] rd
    );
        if (we && (wa == ra) && (ra != XZR)) begin
            return wd;
        end
        return rd;
    endfunction

    // Bypass both operands of a held entry; addresses, dst and ctrl never change
    function automatic entry_t hold_byp(
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd,
        input entry_t            e
    );
        entry_t r;
        r     = e;
        r.rd1 = fwd(we, wa, wd, e.ra1, e.rd1);
        r.rd2 = fwd(we, wa, wd, e.ra2, e.rd2);
        return r;
    endfunction

    // Incoming entry with capture bypass, and held entries with hold bypass
    always_comb begin
        in_c.ra1  = bus.in_ra1;
        in_c.ra2  = bus.in_ra2;
        in_c.rd1  = fwd(bus.wb_we, bus.wb_wa, bus.wb_wd, bus.in_ra1, bus.in_rd1);
        in_c.rd2  = fwd(bus.wb_we, bus.wb_wa, bus.wb_wd, bus.in_ra2, bus.in_rd2);
        in_c.dst  = bus.in_dst;
        in_c.ctrl = bus.in_ctrl;

        // Invalid entries are left untouched so idle data regs do not toggle
        m_hold_c = m_q;
        if (state_q != ST_EMPTY) begin
            m_hold_c = hold_byp(bus.wb_we, bus.wb_wa, bus.wb_wd, m_q);
        end
        s_hold_c = s_q;
        if (state_q == ST_FULL) begin
            s_hold_c = hold_byp(bus.wb_we, bus.wb_wa, bus.wb_wd, s_q);
        end

        accept_c = bus.in_valid & in_ready_q;
        pop_c    = out_valid_q & bus.out_ready;
    end

    // Next-state, entry movement and registered handshake outputs
    always_comb begin
        state_d = state_q;
        m_d     = m_hold_c;
        s_d     = s_hold_c;

        case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    m_d     = in_c;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (pop_c && accept_c) begin
                    m_d = in_c;
                end else if (pop_c) begin
                    state_d = ST_EMPTY;
                end else if (accept_c) begin
                    s_d     = in_c;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a pop can happen
                if (pop_c) begin
                    m_d     = s_hold_c;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush dominates any pop or accept in the same cycle
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // State and data registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            m_q         <= '0;
            s_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rd1   = m_q.rd1;
    assign bus.out_rd2   = m_q.rd2;
    assign bus.out_dst   = m_q.dst;
    assign bus.out_ctrl  = m_q.ctrl;

endmodule
